barrel_shifter_unit: RTL and testbench

- Registered, parameterisable barrel shifter/rotator built as log2(WIDTH) cascaded mux stages, one stage per bit of the shift amount.
- Default operation is rotate-right of an 8-bit word by 0..7. Three further modes are provided: rotate-left, logical shift-right and arithmetic shift-right.
- Sits in the datapath as a single-cycle, valid-qualified operator feeding downstream ALU/packing logic.

---
 rtl/barrel_shifter_unit_if.sv | 22 ++
 rtl/barrel_shifter_unit.sv | 116 +++++++++++
 tb/tb_barrel_shifter_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/barrel_shifter_unit_if.sv
// Operand/result bundle for barrel_shifter_unit: valid-qualified operand in, registered result out.
interface barrel_shifter_unit_if #(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned SHW = $clog2(WIDTH)
);
   logic             i_valid;
   logic [WIDTH-1:0] i_a;
   logic [SHW-1:0]   i_k;
   logic [1:0]       i_mode;
   logic [WIDTH-1:0] o_y;
   logic             o_valid;

   modport master (
      output i_valid, i_a, i_k, i_mode,
      input  o_y, o_valid
   );

   modport slave (
      input  i_valid, i_a, i_k, i_mode,
      output o_y, o_valid
   );
endinterface

// File: rtl/barrel_shifter_unit.sv
// Registered log2(WIDTH)-stage barrel rotator/shifter (ROR, ROL, LSR, ASR).
// Define BARREL_SHIFTER_PIPE_EN to add a mid-cascade pipeline register (latency 2).
module barrel_shifter_unit #(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned SHW = $clog2(WIDTH)
) (
   input logic                  i_clk,
   input logic                  i_rst,
   barrel_shifter_unit_if.slave bus
);

   typedef enum logic [1:0] {
      MODE_ROR = 2'b00,
      MODE_ROL = 2'b01,
      MODE_LSR = 2'b10,
      MODE_ASR = 2'b11
   } mode_e;

   // Applies stages lo..hi-1; each stage moves data right by 2^s with a per-mode fill.
   // ASR fill comes from the current MSB, which stays equal to the original sign bit.
   function automatic logic [WIDTH-1:0] shift_stages(
      input logic [WIDTH-1:0] d,
      input logic [SHW-1:0]   k,
      input mode_e            mode,
      input int unsigned      lo,
      input int unsigned      hi
   );
      logic [WIDTH-1:0] cur;
      logic [WIDTH-1:0] nxt;
      logic [WIDTH-1:0] ext;
      logic             rot;
      logic             fill;
      int unsigned      sh;
      rot = (mode == MODE_ROR) || (mode == MODE_ROL);
      cur = d;
      for (int unsigned s = 0; s < SHW; s++) begin
         if ((s >= lo) && (s < hi) && k[s]) begin
            sh   = 32'd1 << s;
            fill = (mode == MODE_ASR) ? cur[WIDTH-1] : 1'b0;
            ext  = rot ? cur : {WIDTH{fill}};
            nxt  = WIDTH'({ext, cur} >> sh);
            cur  = nxt;
         end
      end
      return cur;
   endfunction

   mode_e            in_mode;
   logic [SHW-1:0]   in_k;
   logic [WIDTH-1:0] y_d, y_q;
   logic             vld_d, vld_q;

   // Rotate-left becomes rotate-right by (WIDTH-k) mod WIDTH, i.e. -k in SHW bits.
   always_comb begin
      in_mode = mode_e'(bus.i_mode);
      in_k    = (in_mode == MODE_ROL) ? ('0 - bus.i_k) : bus.i_k;
   end

`ifdef BARREL_SHIFTER_PIPE_EN
   localparam int unsigned SPLIT = SHW / 2;

   logic [WIDTH-1:0] mid_d, mid_q;
   logic [SHW-1:0]   mid_k_d, mid_k_q;
   mode_e            mid_mode_d, mid_mode_q;
   logic             mid_vld_d, mid_vld_q;

   always_comb begin
      mid_d      = mid_q;
      mid_k_d    = mid_k_q;
      mid_mode_d = mid_mode_q;
      mid_vld_d  = bus.i_valid;
      if (bus.i_valid) begin
         mid_d      = shift_stages(bus.i_a, in_k, in_mode, 0, SPLIT);
         mid_k_d    = in_k;
         mid_mode_d = in_mode;
      end
      vld_d = mid_vld_q;
      y_d   = mid_vld_q ? shift_stages(mid_q, mid_k_q, mid_mode_q, SPLIT, SHW) : y_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mid_q      <= '0;
         mid_k_q    <= '0;
         mid_mode_q <= MODE_ROR;
         mid_vld_q  <= 1'b0;
      end else begin
         mid_q      <= mid_d;
         mid_k_q    <= mid_k_d;
         mid_mode_q <= mid_mode_d;
         mid_vld_q  <= mid_vld_d;
      end
   end
`else
   always_comb begin
      vld_d = bus.i_valid;
      y_d   = bus.i_valid ? shift_stages(bus.i_a, in_k, in_mode, 0, SHW) : y_q;
   end
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         y_q   <= '0;
         vld_q <= 1'b0;
      end else begin
         y_q   <= y_d;
         vld_q <= vld_d;
      end
   end

   always_comb begin
      bus.o_y     = y_q;
      bus.o_valid = vld_q;
   end

endmodule

// File: tb/tb_barrel_shifter_unit.sv
// Directed self-checking bench for barrel_shifter_unit (WIDTH=8); honours BARREL_SHIFTER_PIPE_EN latency.
module tb_barrel_shifter_unit;

`ifdef BARREL_SHIFTER_PIPE_EN
   localparam int unsigned LAT = 2;
`else
   localparam int unsigned LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   barrel_shifter_unit_if #(.WIDTH(8)) bus ();

   barrel_shifter_unit #(.WIDTH(8)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated operation: present it for one edge, then wait out the remaining latency.
   task automatic op(input string tag, input logic [7:0] a, input logic [2:0] k,
                     input logic [1:0] mode, input logic [7:0] exp);
      bus.i_valid = 1'b1;
      bus.i_a     = a;
      bus.i_k     = k;
      bus.i_mode  = mode;
      tick();
      bus.i_valid = 1'b0;
      bus.i_a     = 8'h5A;
      repeat (LAT - 1) tick();
      check({tag, "_y"}, bus.o_y, exp);
      check({tag, "_v"}, {7'b0, bus.o_valid}, 8'h01);
   endtask

   logic [15:0] wide;
   logic [7:0]  ra;
   logic [2:0]  rk;
   logic [7:0]  rexp;

   // Streamed stimulus: back-to-back throughput then a one-cycle valid gap.
   localparam int N = 6;
   logic       s_v   [N] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [7:0] s_a   [N] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'hFF, 8'hB4};
   logic [2:0] s_k   [N] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd3};
   logic [7:0] e_y   [N] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h20, 8'h96};
   logic       e_v   [N] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

   initial begin
      bus.i_valid = 1'b0;
      bus.i_a     = '0;
      bus.i_k     = '0;
      bus.i_mode  = 2'b00;

      #1;
      check("rst_y", bus.o_y, 8'h00);
      check("rst_v", {7'b0, bus.o_valid}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      op("ror_k0", 8'hB4, 3'd0, 2'b00, 8'hB4);
      op("ror_k3", 8'hB4, 3'd3, 2'b00, 8'h96);
      op("ror_k7", 8'hB4, 3'd7, 2'b00, 8'h69);
      op("rol_k3", 8'hB4, 3'd3, 2'b01, 8'hA5);
      op("rol_k1", 8'hB4, 3'd1, 2'b01, 8'h69);
      op("rol_k0", 8'hB4, 3'd0, 2'b01, 8'hB4);
      op("lsr_k3", 8'hB4, 3'd3, 2'b10, 8'h16);
      op("asr_k3", 8'hB4, 3'd3, 2'b11, 8'hF6);
      op("asr_pos", 8'h74, 3'd3, 2'b11, 8'h0E);
      op("lsr_k7", 8'h80, 3'd7, 2'b10, 8'h01);
      op("asr_k7", 8'h80, 3'd7, 2'b11, 8'hFF);
      op("rol_k7", 8'h01, 3'd7, 2'b01, 8'h80);

      for (int i = 0; i < 100; i++) begin
         ra   = 8'($urandom);
         rk   = 3'($urandom_range(7, 0));
         wide = {8'h00, ra};
         rexp = 8'((wide >> rk) | (wide << (4'd8 - {1'b0, rk})));
         op("ror_rand", ra, rk, 2'b00, rexp);
      end

      for (int c = 0; c < N + int'(LAT) - 1; c++) begin
         if (c < N) begin
            bus.i_valid = s_v[c];
            bus.i_a     = s_a[c];
            bus.i_k     = s_k[c];
         end else begin
            bus.i_valid = 1'b0;
         end
         bus.i_mode = 2'b00;
         tick();
         if (c >= int'(LAT) - 1) begin
            check("stream_y", bus.o_y, e_y[c - int'(LAT) + 1]);
            check("stream_v", {7'b0, bus.o_valid}, {7'b0, e_v[c - int'(LAT) + 1]});
         end
      end

      // Reset asserted between edges while valid operands are flowing.
      bus.i_valid = 1'b1;
      bus.i_a     = 8'hC3;
      bus.i_k     = 3'd2;
      bus.i_mode  = 2'b00;
      repeat (2) tick();
      check("pre_rst_v", {7'b0, bus.o_valid}, 8'h01);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_y", bus.o_y, 8'h00);
      check("midrst_v", {7'b0, bus.o_valid}, 8'h00);
      bus.i_valid = 1'b0;
      tick();
      @(negedge clk);
      rst = 1'b0;
      check("postrst_v", {7'b0, bus.o_valid}, 8'h00);
      op("after_rst", 8'hB4, 3'd3, 2'b00, 8'h96);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
